// File: rtl/dcache_ctrl.sv
// dcache_ctrl: tag/control stage of the 2-way, 64-set, 8-byte-line data cache.
// Owns valid/dirty/tag/LRU state, resolves hits combinationally, and runs the
// write-back and refill sequence on the memory bus when an access misses.
//
// Optional build macro: DCACHE_PERF_CNT_EN adds the hit_cnt, miss_cnt and
// wb_cnt 64-bit event counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | accept request; cached hits complete in the same cycle
//   S_WB      | write_back pulse, data array reads the victim line
//   S_WB_WAIT | capture cacheline_old, then write victim to memory
//   S_RF_WAIT | read the missing line from memory
//   S_REFILL  | refresh pulse, install line and update tag state
//   S_UNC_RD  | uncached load on the bus
//   S_UNC_WR  | uncached store on the bus
//   S_DONE    | resp_valid, pipeline released
module dcache_ctrl #(
  parameter int TAG_W = 55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_uncached,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall_req,
  output logic              resp_valid,
  output logic [1:0]        hit,
  output logic              lru,
  output logic              dirty,
  output logic              write_back,
  output logic              refresh,
  output logic [63:0]       cacheline_new,
  input  logic [63:0]       cacheline_old,
  output logic [63:0]       uncached_rdata,
  output logic              mem_rd_req,
  output logic [63:0]       mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [63:0]       mem_rd_data,
  output logic              mem_wr_req,
  output logic [63:0]       mem_wr_addr,
  output logic [63:0]       mem_wr_data,
`ifdef DCACHE_PERF_CNT_EN
  output logic [63:0]       hit_cnt,
  output logic [63:0]       miss_cnt,
  output logic [63:0]       wb_cnt,
`endif
  input  logic              mem_wr_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_WB_WAIT, S_RF_WAIT, S_REFILL, S_UNC_RD, S_UNC_WR, S_DONE
  } state_t;

  state_t             state;
  logic [1:0][63:0]   valid_q;
  logic [1:0][63:0]   dirty_q;
  logic [63:0]        lru_q;
  logic [TAG_W-1:0]   tag_q [0:1][0:63];
  logic               way_q;     // way being replaced by the current miss
  logic               unc_q;     // current transaction bypasses the cache
  logic               wb_lat;    // victim data already captured in WB_WAIT

  logic [5:0]         idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         way_hit;
  logic               hit_way;
  logic               victim;
  logic               victim_dirty;
  logic               hit_now;
  logic               sel_way;

  // Tag compare, victim choice and the combinational pipeline handshake
  always_comb begin
    idx     = req_addr[8:3];
    req_tag = req_addr[63:64-TAG_W];
    way_hit[0] = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    way_hit[1] = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
    hit_way = way_hit[1];
    // An invalid way is always preferred over the LRU pointer
    if (!valid_q[0][idx])      victim = 1'b0;
    else if (!valid_q[1][idx]) victim = 1'b1;
    else                       victim = lru_q[idx];
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
    hit_now = (state == S_IDLE) && req_valid && !req_uncached && (|way_hit);
    // Once a miss is in flight the chosen way is frozen so refresh targets it
    sel_way = (state == S_IDLE) ? victim : way_q;
    lru     = sel_way;
    dirty   = valid_q[sel_way][idx] && dirty_q[sel_way][idx];
    hit = 2'b00;
    if (hit_now)
      hit = way_hit;
    else if ((state == S_DONE) && !unc_q)
      hit = way_q ? 2'b10 : 2'b01;
    resp_valid = hit_now || (state == S_DONE);
    if (state == S_IDLE) stall_req = req_valid && !hit_now;
    else                 stall_req = (state != S_DONE);
  end

  // Sequencer, tag state and registered bus / data-array controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      lru_q          <= '0;
      way_q          <= 1'b0;
      unc_q          <= 1'b0;
      wb_lat         <= 1'b0;
      write_back     <= 1'b0;
      refresh        <= 1'b0;
      cacheline_new  <= '0;
      uncached_rdata <= '0;
      mem_rd_req     <= 1'b0;
      mem_rd_addr    <= '0;
      mem_wr_req     <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_uncached) begin
              unc_q <= 1'b1;
              if (req_we) begin
                mem_wr_req  <= 1'b1;
                mem_wr_addr <= req_addr;
                mem_wr_data <= req_wdata;
                state       <= S_UNC_WR;
              end else begin
                mem_rd_req  <= 1'b1;
                mem_rd_addr <= req_addr;
                state       <= S_UNC_RD;
              end
            end else if (|way_hit) begin
              lru_q[idx] <= ~hit_way;
              if (req_we) dirty_q[hit_way][idx] <= 1'b1;
            end else begin
              unc_q <= 1'b0;
              way_q <= victim;
              if (victim_dirty) begin
                write_back <= 1'b1;
                state      <= S_WB;
              end else begin
                mem_rd_req  <= 1'b1;
                mem_rd_addr <= {req_tag, idx, 3'b000};
                state       <= S_RF_WAIT;
              end
            end
          end
        end
        S_WB: begin
          write_back <= 1'b0;
          wb_lat     <= 1'b0;
          state      <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          // The data array returns the victim the cycle after write_back, so
          // the bus request starts only once that line has been captured.
          if (!wb_lat) begin
            wb_lat      <= 1'b1;
            mem_wr_data <= cacheline_old;
            mem_wr_addr <= {tag_q[way_q][idx], idx, 3'b000};
            mem_wr_req  <= 1'b1;
          end else if (mem_wr_ack) begin
            mem_wr_req  <= 1'b0;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= {req_tag, idx, 3'b000};
            state       <= S_RF_WAIT;
          end
        end
        S_RF_WAIT: begin
          if (mem_rd_valid) begin
            mem_rd_req    <= 1'b0;
            refresh       <= 1'b1;
            // A line is one doubleword, so a store miss replaces it outright
            cacheline_new <= req_we ? req_wdata : mem_rd_data;
            state         <= S_REFILL;
          end
        end
        S_REFILL: begin
          refresh               <= 1'b0;
          valid_q[way_q][idx]   <= 1'b1;
          dirty_q[way_q][idx]   <= req_we;
          tag_q[way_q][idx]     <= req_tag;
          lru_q[idx]            <= ~way_q;
          state                 <= S_DONE;
        end
        S_UNC_RD: begin
          if (mem_rd_valid) begin
            mem_rd_req     <= 1'b0;
            uncached_rdata <= mem_rd_data;
            state          <= S_DONE;
          end
        end
        S_UNC_WR: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Event counters: one increment per hit, per cached miss, per victim write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_now)
        hit_cnt <= hit_cnt + 64'd1;
      if ((state == S_IDLE) && req_valid && !req_uncached && !(|way_hit))
        miss_cnt <= miss_cnt + 64'd1;
      if (state == S_WB)
        wb_cnt <= wb_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Control and tag stage for the 2-way, 64-set, 8-byte-line data cache; it sits directly upstream of the data array and between the MEM pipeline stage and the memory bus. It holds valid/dirty/tag/LRU state, resolves hit/miss, and drives the data array's hit, lru, write_back and refresh controls. On a miss it runs the write-back and refill sequence on the memory bus and stalls the pipeline until the access completes.

## Interface
- TAG_W, 55, tag width (addr[63:9]); index = addr[8:3], offset = addr[2:0]
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage access request
- req_we  in  1  1 = store, 0 = load
- req_uncached  in  1  bypass cache (MMIO)
- req_addr  in  64  byte address
- req_wdata  in  64  store data, pre-aligned
- stall_req  out  1  hold pipeline (drives stall[3] source)
- resp_valid  out  1  access complete this cycle
- hit  out  2  one-hot way hit to data array
- lru  out  1  victim way for current index
- dirty  out  1  victim line dirty
- write_back  out  1  data array: read victim line
- refresh  out  1  data array: write refill line into way lru
- cacheline_new  out  64  refill data to data array
- cacheline_old  in  64  victim data from data array
- uncached_rdata  out  64  load data for uncached access
- mem_rd_req / mem_rd_addr  out  1 / 64  read request, held until mem_rd_valid
- mem_rd_valid / mem_rd_data  in  1 / 64  read response
- mem_wr_req / mem_wr_addr / mem_wr_data  out  1 / 64 / 64  write request, held until mem_wr_ack
- mem_wr_ack  in  1  write accepted

## Operation
- Per set, per way: valid, dirty, tag registers; per set: 1 LRU bit (points at least recently used way).
- States: IDLE, WB (victim read), WB_WAIT, RF_WAIT, REFILL, UNC_RD, UNC_WR, DONE.
- IDLE, req_valid, cached: compare both tags combinationally. Hit: hit one-hot, LRU[index] <= other way, store sets dirty[way]; stay IDLE.
- Miss, victim (way LRU[index]) valid & dirty: -> WB. Else -> RF_WAIT.
- WB: assert write_back one cycle; -> WB_WAIT, latching cacheline_old next cycle. WB_WAIT: mem_wr_req with victim tag/index address, offset 0; on mem_wr_ack -> RF_WAIT.
- RF_WAIT: mem_rd_req, address {tag,index,3'b0}; on mem_rd_valid capture data -> REFILL.
- REFILL: refresh=1, cacheline_new = captured data (store: merged with req_wdata); set valid, tag, dirty=req_we; LRU[index] <= other way; -> DONE.
- DONE: resp_valid=1, hit for refilled way; -> IDLE.
- Uncached load: UNC_RD, mem_rd_req at req_addr; data to uncached_rdata -> DONE. Uncached store: UNC_WR, mem_wr_req; on ack -> DONE. No tag/LRU change.
- Both ways invalid on miss: victim way 0. One invalid: choose the invalid way regardless of LRU.

## Timing
- Reset: all valid/dirty/LRU = 0, state IDLE, every output 0.
- Cached hit: request in cycle T, hit/resp_valid in T, load data from data array valid T+1; stall_req 0.
- Miss: stall_req asserted combinationally in T and held until the DONE cycle, inclusive of the cycle before resp_valid drops it.
- Clean miss latency: T+1 RF_WAIT ... mem_rd_valid at cycle R, REFILL R+1, DONE R+2.
- mem_*_req and addresses stable until the matching valid/ack; a same-cycle ack is accepted.
- req_addr/req_wdata are held stable by the stalled pipeline; the block does not latch them.
- rst mid-transaction aborts immediately; outstanding bus requests are dropped.

## Configuration
- DCACHE_PERF_CNT_EN: adds 64-bit hit_cnt, miss_cnt, wb_cnt outputs, each incremented once per event and cleared on rst. Without it these ports and counters are absent.

## Test plan
- Reset then load 0x1000 -> miss; mem_rd_addr 0x1000; after data 0xDEAD, refresh=1, resp_valid two cycles after mem_rd_valid, LRU[0]=1.
- Repeat load 0x1000 -> hit=2'b01 same cycle, stall_req=0, no bus activity.
- Store 0x1000 hit, then loads to 0x1200 and 0x1400 (same index 0) -> second evicts way 0 dirty: write_back pulse, mem_wr_addr 0x1000, then refill 0x1400.
- Uncached load 0x1000_0000 -> mem_rd_req, uncached_rdata = returned data, valid/tag arrays unchanged.
- mem_rd_valid delayed 20 cycles -> stall_req held throughout, addresses stable.
- rst asserted in WB_WAIT -> next cycle state IDLE, all outputs 0, all lines invalid.
